// File: rtl/jogo_pkg.sv
// Shared state codes for the memory-game controller; the datapath debug logic
// and the top-level 7-segment decoder import the same codes.
package jogo_pkg;

  localparam int ESTADO_W_PADRAO = 5;

  // Codes are fixed because they are shown directly on the debug display.
  typedef enum logic [4:0] {
    INICIAL    = 5'h00,
    PREPARA    = 5'h01,
    ESPERA     = 5'h02,
    REGISTRA   = 5'h04,
    COMPARA    = 5'h05,
    PROXIMO    = 5'h06,
    FIM_ACERTO = 5'h0A,
    FIM_TOUT   = 5'h0D,
    FIM_ERRO   = 5'h0E
  } estado_t;

endpackage

// File: rtl/unidade_controle_jogo.sv
// Moore control unit of the memory game. Timeout handling is compiled in only
// when UNIDADE_CONTROLE_TIMEOUT_EN is defined.
module unidade_controle_jogo
  import jogo_pkg::*;
#(
  parameter int ESTADO_W = ESTADO_W_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                jogada_feita,
  input  logic                igual,
  input  logic                fimC,
  input  logic                fim_timer,
  output logic                zeraC,
  output logic                contaC,
  output logic                zeraR,
  output logic                registraR,
  output logic                zera_timer,
  output logic                conta_timer,
  output logic                pronto,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic [ESTADO_W-1:0] db_estado
);

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  estado_t r_estado;
  estado_t w_proximo;
  logic    w_fim_timer;

  assign w_fim_timer = fim_timer & TIMEOUT_EN;

  always_ff @(posedge clock) begin
    if (!reset) r_estado <= INICIAL;
    else        r_estado <= w_proximo;
  end

  // jogada_feita is a one-cycle pulse with no back-pressure: it is consumed
  // only in ESPERA and silently dropped in any other state.
  always_comb begin
    w_proximo = INICIAL;
    case (r_estado)
      INICIAL:    w_proximo = iniciar ? PREPARA : INICIAL;
      PREPARA:    w_proximo = ESPERA;
      ESPERA: begin
        if (jogada_feita)     w_proximo = REGISTRA;
        else if (w_fim_timer) w_proximo = FIM_TOUT;
        else                  w_proximo = ESPERA;
      end
      REGISTRA:   w_proximo = COMPARA;
      COMPARA: begin
        if (!igual)    w_proximo = FIM_ERRO;
        else if (fimC) w_proximo = FIM_ACERTO;
        else           w_proximo = PROXIMO;
      end
      PROXIMO:    w_proximo = ESPERA;
      FIM_ACERTO: w_proximo = iniciar ? PREPARA : FIM_ACERTO;
      FIM_ERRO:   w_proximo = iniciar ? PREPARA : FIM_ERRO;
      FIM_TOUT:   w_proximo = iniciar ? PREPARA : FIM_TOUT;
      default:    w_proximo = INICIAL;
    endcase
  end

  always_comb begin
    zeraC       = 1'b0;
    contaC      = 1'b0;
    zeraR       = 1'b0;
    registraR   = 1'b0;
    zera_timer  = 1'b0;
    conta_timer = 1'b0;
    pronto      = 1'b0;
    acertou     = 1'b0;
    errou       = 1'b0;
    timeout     = 1'b0;
    case (r_estado)
      PREPARA: begin
        zeraC      = 1'b1;
        zeraR      = 1'b1;
        zera_timer = 1'b1;
      end
      ESPERA:     conta_timer = TIMEOUT_EN;
      REGISTRA: begin
        registraR  = 1'b1;
        zera_timer = 1'b1;
      end
      PROXIMO:    contaC = 1'b1;
      FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TOUT: begin
        pronto  = 1'b1;
        timeout = TIMEOUT_EN;
      end
      default: ;
    endcase
  end

  assign db_estado = ESTADO_W'(r_estado);

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Bench for unidade_controle_jogo: directed vector table, hand-written win
// round and randomized rounds checked against a round-level reference model.
module tb_unidade_controle_jogo;

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  localparam logic [4:0] C_INI = 5'h00, C_PRE = 5'h01, C_ESP = 5'h02, C_REG = 5'h04,
                         C_CMP = 5'h05, C_PRX = 5'h06, C_ACE = 5'h0A, C_TOU = 5'h0D,
                         C_ERR = 5'h0E;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, iniciar, jogada_feita, igual, fimC, fim_timer;
  logic zeraC, contaC, zeraR, registraR, zera_timer, conta_timer;
  logic pronto, acertou, errou, timeout;
  logic [4:0] db_estado;

  unidade_controle_jogo dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .igual(igual), .fimC(fimC), .fim_timer(fim_timer),
    .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
    .zera_timer(zera_timer), .conta_timer(conta_timer), .pronto(pronto),
    .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
  );

  // scoreboard
  logic [14:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int contac_cnt = 0;

  // Expected outputs for a state code, straight from the state/output table.
  function automatic logic [14:0] exp_outs(input logic [4:0] code);
    logic [9:0] o;
    o = '0;  // {zeraC,contaC,zeraR,registraR,zera_timer,conta_timer,pronto,acertou,errou,timeout}
    case (code)
      C_PRE: o = 10'b1010100000;
      C_ESP: o = {5'b00000, TE, 4'b0000};
      C_REG: o = 10'b0001100000;
      C_PRX: o = 10'b0100000000;
      C_ACE: o = 10'b0000001100;
      C_ERR: o = 10'b0000001010;
      C_TOU: o = {6'b000000, 1'b1, 2'b00, TE};
      default: o = '0;
    endcase
    return {o, code};
  endfunction

  function automatic logic [14:0] act_outs();
    return {zeraC, contaC, zeraR, registraR, zera_timer, conta_timer,
            pronto, acertou, errou, timeout, db_estado};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // driver: apply inputs, let one rising edge pass, compare on the falling edge
  task automatic do_cycle(input logic rst, input logic ini, input logic jog,
                          input logic igu, input logic fim, input logic tmr,
                          input logic [4:0] code, input string name);
    logic [14:0] exp_v, act_v;
    exp_q.push_back(exp_outs(code));
    reset = rst; iniciar = ini; jogada_feita = jog; igual = igu; fimC = fim; fim_timer = tmr;
    @(posedge clock);
    @(negedge clock);
    act_v = act_outs();
    exp_v = exp_q.pop_front();
    if (contaC) contac_cnt++;
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got outs=%b estado=%h, expected outs=%b estado=%h",
               name, act_v[14:5], act_v[4:0], exp_v[14:5], exp_v[4:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Reference model: one complete round described by its outcome and position.
  task automatic rand_round(input int n);
    int kind, pos, gap, hold;
    logic [4:0] end_code;
    logic wrong, last;
    kind = $urandom_range(0, 2);  // 0 win, 1 wrong play, 2 timeout
    pos  = $urandom_range(0, 15);
    end_code = C_ACE;
    do_cycle(1, 1, 0, rb(), rb(), 0, C_PRE, "rnd_start");
    do_cycle(1, rb(), 0, rb(), rb(), rb(), C_ESP, "rnd_prep");
    for (int i = 0; i < 16; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        do_cycle(1, rb(), 0, rb(), rb(), TE ? 1'b0 : rb(), C_ESP, "rnd_wait");
      if (kind == 2 && i == pos) begin
        do_cycle(1, 0, 0, rb(), rb(), 1, TE ? C_TOU : C_ESP, "rnd_tout");
        if (TE) begin
          end_code = C_TOU;
          break;
        end
      end
      do_cycle(1, rb(), 1, rb(), rb(), rb(), C_REG, "rnd_play");
      do_cycle(1, rb(), rb(), rb(), rb(), rb(), C_CMP, "rnd_reg");
      wrong = (kind == 1 && i == pos);
      last  = (i == 15);
      end_code = wrong ? C_ERR : (last ? C_ACE : C_PRX);
      do_cycle(1, rb(), 0, !wrong, last, rb(), end_code, "rnd_cmp");
      if (wrong || last) break;
      do_cycle(1, rb(), rb(), rb(), rb(), rb(), C_ESP, "rnd_next");
    end
    hold = $urandom_range(0, 2);
    for (int h = 0; h < hold; h++)
      do_cycle(1, 0, rb(), rb(), rb(), rb(), end_code, "rnd_hold");
  endtask

  typedef struct {
    logic rst, ini, jog, igu, fim, tmr;
    logic [4:0] code;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(input logic rst, input logic ini, input logic jog,
                              input logic igu, input logic fim, input logic tmr,
                              input logic [4:0] code);
    vec_t v;
    v.rst = rst; v.ini = ini; v.jog = jog; v.igu = igu; v.fim = fim; v.tmr = tmr; v.code = code;
    return v;
  endfunction

  initial begin
    //            rst ini jog igu fim tmr  state
    vecs[0]  = mk(0, 1, 0, 0, 0, 0, C_INI);  // reset held with iniciar
    vecs[1]  = mk(0, 1, 0, 0, 0, 0, C_INI);
    vecs[2]  = mk(1, 1, 0, 0, 0, 0, C_PRE);
    vecs[3]  = mk(1, 1, 0, 0, 0, 0, C_ESP);  // iniciar ignored in PREPARA
    vecs[4]  = mk(1, 0, 1, 0, 0, 1, C_REG);  // play and timer together: play wins
    vecs[5]  = mk(1, 0, 0, 1, 0, 0, C_CMP);
    vecs[6]  = mk(1, 0, 0, 1, 0, 0, C_PRX);
    vecs[7]  = mk(1, 0, 1, 0, 0, 0, C_ESP);  // play in PROXIMO dropped
    vecs[8]  = mk(1, 0, 0, 0, 0, 0, C_ESP);
    vecs[9]  = mk(1, 0, 1, 0, 0, 0, C_REG);
    vecs[10] = mk(1, 0, 0, 0, 0, 0, C_CMP);
    vecs[11] = mk(1, 0, 0, 1, 0, 0, C_PRX);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, C_ESP);
    vecs[13] = mk(1, 0, 1, 0, 0, 0, C_REG);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, C_CMP);
    vecs[15] = mk(1, 0, 0, 0, 0, 0, C_ERR);  // third play wrong
    vecs[16] = mk(1, 0, 0, 0, 0, 0, C_ERR);
    vecs[17] = mk(1, 1, 0, 0, 0, 0, C_PRE);  // restart from FIM_ERRO
    vecs[18] = mk(1, 0, 0, 0, 0, 0, C_ESP);
    vecs[19] = mk(1, 0, 1, 0, 0, 0, C_REG);
    vecs[20] = mk(1, 0, 0, 0, 0, 0, C_CMP);
    vecs[21] = mk(0, 0, 0, 1, 0, 0, C_INI);  // reset while in COMPARA
    vecs[22] = mk(1, 0, 0, 0, 0, 0, C_INI);
    vecs[23] = mk(1, 1, 0, 0, 0, 0, C_PRE);
    vecs[24] = mk(1, 0, 0, 0, 0, 0, C_ESP);
    vecs[25] = mk(1, 0, 0, 0, 0, 1, TE ? C_TOU : C_ESP);
    vecs[26] = mk(1, 0, 0, 0, 0, 0, TE ? C_TOU : C_ESP);
    vecs[27] = mk(1, 1, 0, 0, 0, 0, TE ? C_PRE : C_ESP);
    vecs[28] = mk(1, 0, 0, 0, 0, 0, C_ESP);

    reset = 0; iniciar = 0; jogada_feita = 0; igual = 0; fimC = 0; fim_timer = 0;

    for (int i = 0; i < 29; i++) begin
      if (i == 2) contac_cnt = 0;
      do_cycle(vecs[i].rst, vecs[i].ini, vecs[i].jog, vecs[i].igu, vecs[i].fim,
               vecs[i].tmr, vecs[i].code, $sformatf("vec%0d", i));
      if (i == 16) check_int("contaC_before_error", contac_cnt, 2);
    end

    // full winning round: 16 plays, 15 address increments
    do_cycle(0, 0, 0, 0, 0, 0, C_INI, "win_reset");
    do_cycle(1, 1, 0, 0, 0, 0, C_PRE, "win_start");
    contac_cnt = 0;
    do_cycle(1, 0, 0, 0, 0, 0, C_ESP, "win_prep");
    for (int p = 0; p < 16; p++) begin
      do_cycle(1, 0, 1, 0, 0, 0, C_REG, "win_play");
      do_cycle(1, 0, 0, 0, 0, 0, C_CMP, "win_reg");
      do_cycle(1, 0, 0, 1, p == 15, 0, (p == 15) ? C_ACE : C_PRX, "win_cmp");
      if (p != 15) do_cycle(1, 0, 0, 0, 0, 0, C_ESP, "win_next");
    end
    check_int("contaC_win_count", contac_cnt, 15);
    check_int("win_pronto_acertou", int'({pronto, acertou}), 3);
    do_cycle(1, 0, 1, 0, 0, 1, C_ACE, "win_hold");

    // randomized rounds against the round-level model
    for (int n = 0; n < 25; n++) rand_round(n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected completion before 200000");
    $fatal(1);
  end

endmodule
